dmem_access_ctrl: RTL and testbench

- Sequences data-memory accesses for the load/store stage of the integer pipeline.
- Accepts one load or store per instruction from the pipeline, checks alignment, and drives a req/ack memory bus with word address, byte enables and lane-replicated write data.
- Stalls the pipeline until the access completes, then returns load data shifted to lane 0 for the write-back stage.
- The write-back stage does the sign/zero extension by funct3.

---
 rtl/dmem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dmem_access_ctrl : load/store sequencer driving a req/ack data-memory bus
// Revision: 1.0
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        fault_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [3:0]  bus_be_out,
  output logic [31:0] bus_wdata_out,
  input  logic        bus_ack_in,
  input  logic        bus_err_in,
  input  logic [31:0] bus_rdata_in
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  lane_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        size_ok_d;
  logic        align_ok_d;
  logic        legal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;
  logic [7:0]  cnt_d;

  // Opcode legality, alignment and lane steering for the op on the inputs.
  always_comb begin
    size_ok_d  = 1'b0;
    align_ok_d = 1'b0;
    be_d       = 4'hF;
    wdata_d    = wdata_in;
    case (funct3_in)
      3'd0, 3'd1, 3'd2: size_ok_d = 1'b1;
      3'd4, 3'd5:       size_ok_d = ~mem_write_in;
      default:          size_ok_d = 1'b0;
    endcase
    case (funct3_in[1:0])
      2'd0: begin
        align_ok_d = 1'b1;
        be_d       = 4'b0001 << addr_in[1:0];
        wdata_d    = {4{wdata_in[7:0]}};
      end
      2'd1: begin
        align_ok_d = ~addr_in[0];
        be_d       = 4'b0011 << addr_in[1:0];
        wdata_d    = {2{wdata_in[15:0]}};
      end
      2'd2: begin
        align_ok_d = (addr_in[1:0] == 2'b00);
        be_d       = 4'hF;
        wdata_d    = wdata_in;
      end
      default: begin
        align_ok_d = 1'b0;
        be_d       = 4'hF;
        wdata_d    = wdata_in;
      end
    endcase
    legal_d = size_ok_d & align_ok_d;
    rdata_d = bus_rdata_in >> {lane_q, 3'b000};
    cnt_d   = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      lane_q  <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_valid_in) begin
            if (legal_d) begin
              state_q <= S_REQ;
              cnt_q   <= 8'd0;
              lane_q  <= addr_in[1:0];
              req_q   <= 1'b1;
              we_q    <= mem_write_in;
              addr_q  <= {addr_in[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end else begin
              state_q <= S_FAULT;
            end
          end
        end
        S_REQ: begin
          // An ack on the final permitted cycle still counts as a completion.
          if (bus_ack_in) begin
            req_q <= 1'b0;
            if (bus_err_in) begin
              state_q <= S_FAULT;
            end else begin
              state_q <= S_DONE;
              if (!we_q) begin
                rdata_q <= rdata_d;
              end
            end
          end else if (cnt_d == TIMEOUT_C) begin
            req_q   <= 1'b0;
            state_q <= S_FAULT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out       = ~reset & (((state_q == S_IDLE) & mem_valid_in) | (state_q == S_REQ));
  assign rdata_valid_out = (state_q == S_DONE);
  assign fault_out       = (state_q == S_FAULT);
  assign rdata_out       = rdata_q;
  assign bus_req_out     = req_q;
  assign bus_we_out      = we_q;
  assign bus_addr_out    = addr_q;
  assign bus_be_out      = be_q;
  assign bus_wdata_out   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// Testbench for dmem_access_ctrl: directed scenarios plus randomized ops
// checked against an arithmetic model of the load/store rules.
module tb_dmem_access_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall_out, rdata_valid_out, fault_out;
  logic [31:0] rdata_out;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in, bus_err_in;
  logic [31:0] bus_rdata_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rv_cyc = 0;
  int req_rise_cyc = 0;
  logic [31:0] rdata_model = 32'd0;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mem_valid_in(mem_valid_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .rdata_out(rdata_out),
    .rdata_valid_out(rdata_valid_out), .fault_out(fault_out),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out),
    .bus_addr_out(bus_addr_out), .bus_be_out(bus_be_out),
    .bus_wdata_out(bus_wdata_out), .bus_ack_in(bus_ack_in),
    .bus_err_in(bus_err_in), .bus_rdata_in(bus_rdata_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic bit m_legal(bit w, logic [2:0] f3, logic [31:0] a);
    int sz;
    bit ok;
    sz = 1 << f3[1:0];
    if (w) ok = f3 inside {3'd0, 3'd1, 3'd2};
    else   ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return ok && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] d);
    int sz;
    sz = 1 << f3[1:0];
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_rdata(logic [31:0] r, logic [31:0] a);
    return r >> (8 * (a % 4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op from its IDLE cycle and returns in the following IDLE cycle.
  // ack_at: REQ cycle index (0-based) carrying the ack; >= TO means no ack.
  task automatic run_op(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input bit err,
                        input logic [31:0] rd, input string tag);
    bit ok;
    ok = m_legal(w, f3, a);
    mem_valid_in = 1'b1; mem_write_in = w; funct3_in = f3; addr_in = a; wdata_in = d;
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL %s idle_stall got=%b exp=1", tag, stall_out); end
    checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL %s idle_req got=%b exp=0", tag, bus_req_out); end
    tick();
    if (!ok) begin
      checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL %s illegal_fault got=%b exp=1", tag, fault_out); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL %s illegal_stall got=%b exp=0", tag, stall_out); end
      checks++; if (rdata_valid_out !== 1'b0) begin errors++; $display("FAIL %s illegal_rvalid got=%b exp=0", tag, rdata_valid_out); end
      checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL %s illegal_req got=%b exp=0", tag, bus_req_out); end
      mem_valid_in = 1'b0;
      tick();
      checks++; if (bus_req_out !== 1'b0 || fault_out !== 1'b0) begin errors++; $display("FAIL %s illegal_after req=%b fault=%b exp=0,0", tag, bus_req_out, fault_out); end
      return;
    end
    req_rise_cyc = cyc;
    for (int i = 0; i < TO; i++) begin
      checks++; if (bus_req_out !== 1'b1) begin errors++; $display("FAIL %s req_%0d got=%b exp=1", tag, i, bus_req_out); end
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL %s req_stall_%0d got=%b exp=1", tag, i, stall_out); end
      checks++; if (bus_addr_out !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s addr got=%h exp=%h", tag, bus_addr_out, a & 32'hFFFF_FFFC); end
      checks++; if (bus_be_out !== m_be(f3, a)) begin errors++; $display("FAIL %s be got=%h exp=%h", tag, bus_be_out, m_be(f3, a)); end
      checks++; if (bus_we_out !== w) begin errors++; $display("FAIL %s we got=%b exp=%b", tag, bus_we_out, w); end
      if (w) begin
        checks++; if (bus_wdata_out !== m_wdata(f3, d)) begin errors++; $display("FAIL %s wdata got=%h exp=%h", tag, bus_wdata_out, m_wdata(f3, d)); end
      end
      if (i == ack_at) begin bus_ack_in = 1'b1; bus_err_in = err; bus_rdata_in = rd; end
      tick();
      bus_ack_in = 1'b0; bus_err_in = 1'b0; bus_rdata_in = $urandom;
      if (i == ack_at) break;
    end
    if (ack_at < TO && !err) begin
      if (!w) rdata_model = m_rdata(rd, a);
      last_rv_cyc = cyc;
      checks++; if (rdata_valid_out !== 1'b1) begin errors++; $display("FAIL %s done_rvalid got=%b exp=1", tag, rdata_valid_out); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL %s done_stall got=%b exp=0", tag, stall_out); end
      checks++; if (fault_out !== 1'b0) begin errors++; $display("FAIL %s done_fault got=%b exp=0", tag, fault_out); end
    end else begin
      checks++; if (fault_out !== 1'b1) begin errors++; $display("FAIL %s end_fault got=%b exp=1", tag, fault_out); end
      checks++; if (rdata_valid_out !== 1'b0) begin errors++; $display("FAIL %s end_rvalid got=%b exp=0", tag, rdata_valid_out); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL %s end_stall got=%b exp=0", tag, stall_out); end
    end
    checks++; if (bus_req_out !== 1'b0) begin errors++; $display("FAIL %s end_req got=%b exp=0", tag, bus_req_out); end
    checks++; if (rdata_out !== rdata_model) begin errors++; $display("FAIL %s rdata got=%h exp=%h", tag, rdata_out, rdata_model); end
    mem_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_valid_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'd0;
    addr_in = 32'd0; wdata_in = 32'd0; bus_ack_in = 1'b0; bus_err_in = 1'b0; bus_rdata_in = 32'd0;
    #1;
    checks++; if ({stall_out, rdata_valid_out, fault_out, bus_req_out, bus_we_out} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {stall_out, rdata_valid_out, fault_out, bus_req_out, bus_we_out}); end
    checks++; if ({rdata_out, bus_addr_out, bus_wdata_out, bus_be_out} !== 100'b0) begin errors++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%h exp=0", rdata_out, bus_addr_out, bus_wdata_out, bus_be_out); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_loads_stores();
    run_op(1'b0, 3'd2, 32'h100, 32'h0, 1, 1'b0, 32'hDEADBEEF, "lw");
    run_op(1'b1, 3'd0, 32'h203, 32'hA5, 0, 1'b0, 32'h0, "sb");
    run_op(1'b0, 3'd5, 32'h302, 32'h0, 0, 1'b0, 32'h1234ABCD, "lhu");
    run_op(1'b1, 3'd1, 32'h306, 32'hCAFE_BEEF, 2, 1'b0, 32'h0, "sh");
    run_op(1'b0, 3'd4, 32'h401, 32'h0, 0, 1'b0, 32'h89ABCDEF, "lbu");
  endtask

  task automatic test_illegal();
    run_op(1'b0, 3'd1, 32'h301, 32'h0, 0, 1'b0, 32'h0, "lh_misal");
    run_op(1'b1, 3'd3, 32'h300, 32'h0, 0, 1'b0, 32'h0, "sw_f3_3");
    run_op(1'b1, 3'd4, 32'h300, 32'h0, 0, 1'b0, 32'h0, "store_f3_4");
    run_op(1'b0, 3'd6, 32'h300, 32'h0, 0, 1'b0, 32'h0, "load_f3_6");
    run_op(1'b0, 3'd2, 32'h302, 32'h0, 0, 1'b0, 32'h0, "lw_misal");
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'd2, 32'h500, 32'h0, TO, 1'b0, 32'h0, "timeout");
    tick();
    bus_ack_in = 1'b1; bus_rdata_in = 32'h5555_AAAA;
    tick();
    bus_ack_in = 1'b0;
    checks++; if (rdata_valid_out !== 1'b0 || fault_out !== 1'b0 || bus_req_out !== 1'b0) begin errors++; $display("FAIL late_ack rvalid=%b fault=%b req=%b exp=0,0,0", rdata_valid_out, fault_out, bus_req_out); end
    checks++; if (rdata_out !== rdata_model) begin errors++; $display("FAIL late_ack_rdata got=%h exp=%h", rdata_out, rdata_model); end
    run_op(1'b0, 3'd2, 32'h504, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, "ack_at_limit");
  endtask

  task automatic test_bus_err();
    run_op(1'b0, 3'd2, 32'h600, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, "bus_err");
  endtask

  task automatic test_reset_mid();
    mem_valid_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'd2; addr_in = 32'h700;
    tick();
    checks++; if (bus_req_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b exp=1", bus_req_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({stall_out, rdata_valid_out, fault_out, bus_req_out, bus_we_out} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {stall_out, rdata_valid_out, fault_out, bus_req_out, bus_we_out}); end
    checks++; if ({rdata_out, bus_addr_out, bus_be_out} !== 68'b0) begin errors++; $display("FAIL rst_mid_data rdata=%h addr=%h be=%h exp=0", rdata_out, bus_addr_out, bus_be_out); end
    mem_valid_in = 1'b0;
    tick();
    reset = 1'b0;
    rdata_model = 32'd0;
    bus_ack_in = 1'b1; bus_rdata_in = 32'h1357_9BDF;
    tick();
    bus_ack_in = 1'b0;
    checks++; if (rdata_valid_out !== 1'b0 || bus_req_out !== 1'b0 || rdata_out !== 32'd0) begin errors++; $display("FAIL rst_late_ack rvalid=%b req=%b rdata=%h exp=0,0,0", rdata_valid_out, bus_req_out, rdata_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int first_rv;
    run_op(1'b0, 3'd2, 32'h800, 32'h0, 0, 1'b0, 32'h1111_2222, "b2b_first");
    first_rv = last_rv_cyc;
    run_op(1'b0, 3'd2, 32'h804, 32'h0, 1, 1'b0, 32'h3333_4444, "b2b_second");
    checks++; if (req_rise_cyc - first_rv !== 2) begin errors++; $display("FAIL b2b_gap got=%0d exp=2", req_rise_cyc - first_rv); end
  endtask

  task automatic test_random();
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_op(w, f3, a, $urandom, $urandom_range(0, TO), ($urandom_range(0, 7) == 0), $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_loads_stores();
    test_illegal();
    test_timeout();
    test_bus_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
